// File: rtl/ddr_wr_burst_axi.sv
// ddr_wr_burst_axi
// Turns one upstream burst request into a single AXI4 write transaction
// (AW, then len W beats, then B). Only one burst is ever in flight.
//
// Ports
//   ddr_clk, ddr_rst         : clock, synchronous active-high reset
//   wr_burst_req/len/addr    : upstream request (len in beats, 1..256)
//   wr_burst_data_req        : pop strobe to the upstream FWFT FIFO
//   wr_burst_data            : FIFO head, valid in the cycle of the pop
//   wr_burst_finish          : one-cycle pulse when the burst completes
//   m_axi_aw* / m_axi_w* / m_axi_b* : AXI4 write channels (master side)
//   busy                     : high whenever the FSM is not idle
//   len_err                  : sticky, a request with an illegal length was seen
//   bresp_err_cnt            : saturating count of non-OKAY write responses
module ddr_wr_burst_axi #(
    parameter int         DDR_ADDR_WD = 32,
    parameter int         DDR_DATA_WD = 512,
    parameter int         ADDR_SHIFT  = 3,
    parameter logic [3:0] AXI_ID      = 4'd0
) (
    input  logic                     ddr_clk,
    input  logic                     ddr_rst,
    input  logic                     wr_burst_req,
    input  logic [9:0]               wr_burst_len,
    input  logic [DDR_ADDR_WD-1:0]   wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [DDR_DATA_WD-1:0]   wr_burst_data,
    output logic                     wr_burst_finish,
    output logic [3:0]               m_axi_awid,
    output logic [DDR_ADDR_WD-1:0]   m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic [3:0]               m_axi_awcache,
    output logic [2:0]               m_axi_awprot,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [DDR_DATA_WD-1:0]   m_axi_wdata,
    output logic [DDR_DATA_WD/8-1:0] m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [3:0]               m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic                     busy,
    output logic                     len_err,
    output logic [15:0]              bresp_err_cnt
);

    localparam int         STRB_W = DDR_DATA_WD / 8;
    localparam logic [2:0] AWSIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

    state_t                 state_p0, state_nxt;
    logic [DDR_ADDR_WD-1:0] addr_p0;
    logic [7:0]             len_m1_p0;
    logic [7:0]             beat_cnt_p0;
    logic                   len_ok;
    logic                   aw_hs, w_hs, b_hs;
    logic                   bid_unused;

    // Only one burst is outstanding, so the response ID carries no information.
    assign bid_unused = ^m_axi_bid;

    assign len_ok = (wr_burst_len != 10'd0) && (wr_burst_len <= 10'd256);

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_p0 << ADDR_SHIFT;
    assign m_axi_awlen   = len_m1_p0;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;

    assign m_axi_wdata   = wr_burst_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = m_axi_wvalid && (beat_cnt_p0 == len_m1_p0);

    // The FIFO is FWFT, so a beat is consumed exactly when the W handshake happens.
    assign wr_burst_data_req = w_hs;

    assign busy = (state_p0 != IDLE);

    // Next state and handshake outputs; reset forces everything quiet
    // in the same cycle so no handshake can complete while ddr_rst is high.
    always_comb begin
        state_nxt       = state_p0;
        m_axi_awvalid   = 1'b0;
        m_axi_wvalid    = 1'b0;
        m_axi_bready    = 1'b0;
        wr_burst_finish = 1'b0;
        if (!ddr_rst) begin
            case (state_p0)
                IDLE: begin
                    if (wr_burst_req && len_ok) state_nxt = AW;
                end
                AW: begin
                    m_axi_awvalid = 1'b1;
                    if (m_axi_awready) state_nxt = W;
                end
                W: begin
                    m_axi_wvalid = 1'b1;
                    if (m_axi_wready && (beat_cnt_p0 == len_m1_p0)) state_nxt = B;
                end
                B: begin
                    m_axi_bready = 1'b1;
                    if (m_axi_bvalid) state_nxt = DONE;
                end
                DONE: begin
                    // Request is deliberately ignored here so upstream can
                    // advance its address before being sampled again.
                    wr_burst_finish = 1'b1;
                    state_nxt       = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control state
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_p0      <= IDLE;
            beat_cnt_p0   <= 8'd0;
            len_err       <= 1'b0;
            bresp_err_cnt <= 16'd0;
        end else begin
            state_p0 <= state_nxt;
            if (state_p0 == IDLE && wr_burst_req && !len_ok) len_err <= 1'b1;
            if (aw_hs)     beat_cnt_p0 <= 8'd0;
            else if (w_hs) beat_cnt_p0 <= beat_cnt_p0 + 8'd1;
            if (b_hs && (m_axi_bresp != 2'b00) && (bresp_err_cnt != 16'hFFFF))
                bresp_err_cnt <= bresp_err_cnt + 16'd1;
        end
    end

    // Burst parameters latched at acceptance
    always_ff @(posedge ddr_clk) begin
        if (state_p0 == IDLE && wr_burst_req && len_ok) begin
            addr_p0   <= wr_burst_addr;
            len_m1_p0 <= 8'(wr_burst_len - 10'd1);
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_axi.sv
// Directed bench for ddr_wr_burst_axi: a cycle-stepped AXI slave and a
// counting FWFT FIFO model surround the DUT; each step compares against
// hand-computed values.
module tb_ddr_wr_burst_axi;

    logic         ddr_clk = 1'b0;
    logic         ddr_rst;
    logic         wr_burst_req;
    logic [9:0]   wr_burst_len;
    logic [31:0]  wr_burst_addr;
    logic         wr_burst_data_req;
    logic [511:0] wr_burst_data;
    logic         wr_burst_finish;
    logic [3:0]   m_axi_awid;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic [3:0]   m_axi_awcache;
    logic [2:0]   m_axi_awprot;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [511:0] m_axi_wdata;
    logic [63:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [3:0]   m_axi_bid;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;
    logic         busy;
    logic         len_err;
    logic [15:0]  bresp_err_cnt;

    ddr_wr_burst_axi dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .len_err(len_err), .bresp_err_cnt(bresp_err_cnt)
    );

    always #5 ddr_clk = ~ddr_clk;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    // FWFT FIFO model: head word is a running index, reset with the DUT.
    logic [31:0] head_idx;
    logic [31:0] head_word;
    assign head_word     = 32'hC0DE0000 + head_idx;
    assign wr_burst_data = {16{head_word}};

    always @(posedge ddr_clk) begin
        if (ddr_rst) head_idx <= 32'd0;
        else if (wr_burst_data_req) head_idx <= head_idx + 32'd1;
        if (!ddr_rst && m_axi_awvalid && m_axi_wvalid) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent burst
    int          g_pops, g_wlast_err, g_wdata_err, g_aw_unstable, g_pop_early;
    int          g_fin, g_finlat, g_aw_cycles;
    logic [31:0] g_awaddr;
    logic [7:0]  g_awlen;
    logic        g_after_fin, g_after_busy, g_after_aw;

    // Runs one burst against the slave model and records what it saw.
    task automatic do_burst(input int len, input logic [31:0] addr, input int aw_delay,
                            input bit w_toggle, input logic [1:0] bresp,
                            input int b_delay, input bit hold_req);
        int          aw_wait, bw, cyc, b_cyc;
        bit          aw_done, w_done, b_done, first_aw, tog;
        logic [31:0] start, w;
        g_pops = 0; g_wlast_err = 0; g_wdata_err = 0; g_aw_unstable = 0;
        g_pop_early = 0; g_fin = 0; g_finlat = -1; g_aw_cycles = 0;
        g_awaddr = 32'hX; g_awlen = 8'hX;
        aw_wait = 0; bw = 0; cyc = 0; b_cyc = 0;
        aw_done = 0; w_done = 0; b_done = 0; first_aw = 1; tog = 0;
        start = head_idx;
        wr_burst_req = 1'b1; wr_burst_len = 10'(len); wr_burst_addr = addr;
        m_axi_bresp = bresp;
        while (g_fin == 0 && cyc < 1000) begin
            @(posedge ddr_clk); #1; cyc++;
            if (busy && !hold_req) wr_burst_req = 1'b0;
            if (w_done) bw++;
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            tog = ~tog;
            m_axi_wready  = w_toggle ? tog : 1'b1;
            m_axi_bvalid  = w_done && !b_done && (bw >= b_delay);
            #1;
            if (wr_burst_data_req) begin
                if (!aw_done) g_pop_early++;
                if (!(m_axi_wvalid && m_axi_wready)) g_wdata_err++;
                w = 32'hC0DE0000 + start + 32'(g_pops);
                if (m_axi_wdata !== {16{w}}) g_wdata_err++;
                if (m_axi_wlast !== (g_pops == len - 1)) g_wlast_err++;
                g_pops++;
                if (m_axi_wlast) w_done = 1;
            end
            if (m_axi_awvalid) begin
                g_aw_cycles++;
                if (first_aw) begin
                    g_awaddr = m_axi_awaddr; g_awlen = m_axi_awlen; first_aw = 0;
                end else if (m_axi_awaddr !== g_awaddr || m_axi_awlen !== g_awlen) begin
                    g_aw_unstable++;
                end
                if (m_axi_awready) aw_done = 1; else aw_wait++;
            end
            if (m_axi_bvalid && m_axi_bready) begin b_done = 1; b_cyc = cyc; end
            if (wr_burst_finish) begin g_fin++; g_finlat = cyc - b_cyc; end
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        @(posedge ddr_clk); #2;
        g_after_fin = wr_burst_finish; g_after_busy = busy; g_after_aw = m_axi_awvalid;
    endtask

    initial begin
        int pops, busy_seen, fin_seen;
        bit hit;
        ddr_rst = 1'b1; wr_burst_req = 1'b0; wr_burst_len = 10'd0; wr_burst_addr = 32'd0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = 4'd0;
        repeat (3) @(posedge ddr_clk);
        #2;
        // Reset state and constant AW/W fields
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_pop", wr_burst_data_req, 0);
        chk("rst_finish", wr_burst_finish, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_bresp_cnt", bresp_err_cnt, 0);
        chk("awsize", m_axi_awsize, 6);
        chk("awburst", m_axi_awburst, 1);
        chk("awcache", m_axi_awcache, 3);
        chk("awprot", m_axi_awprot, 0);
        chk("awid", m_axi_awid, 0);
        chk("wstrb", m_axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge ddr_clk); #1; ddr_rst = 1'b0;

        // Basic burst: len 16 at 0x100, B two cycles after wlast
        do_burst(16, 32'h100, 0, 0, 2'b00, 2, 0);
        chk("t1_awaddr", g_awaddr, 32'h800);
        chk("t1_awlen", g_awlen, 15);
        chk("t1_pops", g_pops, 16);
        chk("t1_wlast", g_wlast_err, 0);
        chk("t1_wdata", g_wdata_err, 0);
        chk("t1_finish", g_fin, 1);
        chk("t1_fin_lat", g_finlat, 1);
        chk("t1_fin_after", g_after_fin, 0);
        chk("t1_busy_after", g_after_busy, 0);

        // AW backpressure: awready low for 5 cycles
        do_burst(16, 32'h20, 5, 0, 2'b00, 0, 0);
        chk("t2_awaddr", g_awaddr, 32'h100);
        chk("t2_aw_cycles", g_aw_cycles, 6);
        chk("t2_aw_stable", g_aw_unstable, 0);
        chk("t2_pop_early", g_pop_early, 0);
        chk("t2_pops", g_pops, 16);
        chk("t2_finish", g_fin, 1);

        // W backpressure: wready toggling, len 4
        do_burst(4, 32'h7, 0, 1, 2'b00, 0, 0);
        chk("t3_awaddr", g_awaddr, 32'h38);
        chk("t3_awlen", g_awlen, 3);
        chk("t3_pops", g_pops, 4);
        chk("t3_wdata", g_wdata_err, 0);
        chk("t3_wlast", g_wlast_err, 0);
        chk("t3_finish", g_fin, 1);

        // Illegal lengths 0 and 300
        busy_seen = 0;
        wr_burst_req = 1'b1; wr_burst_len = 10'd0; wr_burst_addr = 32'h40;
        repeat (3) begin
            @(posedge ddr_clk); #2;
            if (busy || m_axi_awvalid) busy_seen++;
        end
        chk("t4_len_err0", len_err, 1);
        wr_burst_len = 10'd300;
        repeat (3) begin
            @(posedge ddr_clk); #2;
            if (busy || m_axi_awvalid) busy_seen++;
        end
        chk("t4_no_traffic", busy_seen, 0);
        wr_burst_req = 1'b0;
        do_burst(1, 32'h3, 0, 0, 2'b00, 1, 0);
        chk("t4_len1_awlen", g_awlen, 0);
        chk("t4_len1_pops", g_pops, 1);
        chk("t4_len1_wlast", g_wlast_err, 0);
        chk("t4_len1_finish", g_fin, 1);
        chk("t4_len_err_sticky", len_err, 1);

        // Error responses with request held high
        do_burst(8, 32'h40, 0, 0, 2'b10, 1, 1);
        chk("t5a_finish", g_fin, 1);
        chk("t5a_idle_gap_aw", g_after_aw, 0);
        chk("t5a_idle_gap_busy", g_after_busy, 0);
        chk("t5a_cnt", bresp_err_cnt, 1);
        @(posedge ddr_clk); #2;
        chk("t5a_next_aw", m_axi_awvalid, 1);
        do_burst(8, 32'h40, 0, 0, 2'b10, 1, 0);
        chk("t5b_finish", g_fin, 1);
        chk("t5b_pops", g_pops, 8);
        chk("t5b_cnt", bresp_err_cnt, 2);

        // Reset on beat 7 of 16
        wr_burst_req = 1'b1; wr_burst_len = 10'd16; wr_burst_addr = 32'h10;
        pops = 0; hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge ddr_clk); #1;
            if (busy) wr_burst_req = 1'b0;
            m_axi_awready = 1'b1; m_axi_wready = 1'b1;
            #1;
            if (wr_burst_data_req) begin
                if (pops == 7) begin ddr_rst = 1'b1; hit = 1; end
                pops++;
            end
        end
        chk("t6_reached_beat7", hit, 1);
        fin_seen = 0;
        @(posedge ddr_clk); #2;
        chk("t6_awvalid", m_axi_awvalid, 0);
        chk("t6_wvalid", m_axi_wvalid, 0);
        chk("t6_bready", m_axi_bready, 0);
        chk("t6_busy", busy, 0);
        if (wr_burst_finish) fin_seen++;
        ddr_rst = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        repeat (3) begin
            @(posedge ddr_clk); #2;
            if (wr_burst_finish || busy) fin_seen++;
        end
        chk("t6_no_finish", fin_seen, 0);
        chk("t6_cnt_cleared", bresp_err_cnt, 0);
        chk("t6_len_err_cleared", len_err, 0);
        do_burst(16, 32'h100, 0, 0, 2'b00, 0, 0);
        chk("t6_fresh_awaddr", g_awaddr, 32'h800);
        chk("t6_fresh_pops", g_pops, 16);
        chk("t6_fresh_wdata", g_wdata_err, 0);
        chk("t6_fresh_finish", g_fin, 1);

        chk("aw_w_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
